// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants for the convolution datapath
// Provides the pixel word width, the kernel size and the window slice index helper.
package cnn_pkg;

  localparam int DATA_W = 32;  // fp32 bit pattern, never interpreted
  localparam int K      = 3;   // kernel / window size

  // Flat index of window element (i = row offset, j = col offset) inside out_win.
  function automatic int win_idx(input int i, input int j);
    return K * i + j;
  endfunction

endpackage

// File: rtl/conv_window_streamer_if.sv
// rtl/conv_window_streamer_if.sv - pixel-in / window-out handshake bundle
// Ports: in_valid/in_ready/in_data (pixel stream, raster order),
//        out_valid/out_ready/out_win/out_row/out_col/out_last (3x3 window stream).
// slave  : the streamer side (consumes pixels, produces windows)
// master : the environment side (produces pixels, consumes windows)
interface conv_window_streamer_if #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = cnn_pkg::DATA_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [9*DATA_W-1:0]        out_win;
  logic [$clog2(IMG_H)-1:0]   out_row;
  logic [$clog2(IMG_W)-1:0]   out_col;
  logic                       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last
  );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of pixel storage, read-before-write
// Ports: clk; we (write strobe); addr (column); wdata (word stored at addr);
//        rdata (word at addr before this cycle's write, combinational).
// Contents are not reset: the streamer masks stale rows with its row counter.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_streamer.sv
// rtl/conv_window_streamer.sv - raster pixel stream to 3x3 valid-convolution windows
// Ports: clk, rst_n (async active-low);
//        bus (slave modport): pixel input handshake and window output handshake.
// Each accepted pixel shifts a new column {two rows up, one row up, pixel} into the
// window; once the pixel sits at row>=2, col>=2 the window is complete and is
// registered onto the output. There is no FSM: fill vs stream falls out of r/c.
module conv_window_streamer
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_window_streamer_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]                c;
  logic [RW-1:0]                r;
  logic                         acc;
  logic                         last_col;
  logic                         last_row;
  logic                         emit;
  logic [DATA_W-1:0]            lb0_rd;
  logic [DATA_W-1:0]            lb1_rd;
  logic [K*K-1:0][DATA_W-1:0]   win;
  logic [K*K-1:0][DATA_W-1:0]   win_shift;

  // A stalled window blocks input so it can never be overwritten.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign last_col     = (c == CW'(IMG_W - 1));
  assign last_row     = (r == RW'(IMG_H - 1));
  assign emit         = acc && (r >= RW'(2)) && (c >= CW'(2));

  // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from lb0's
  // old word at the same column so both rows move down together.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk   (clk),
    .we    (acc),
    .addr  (c),
    .wdata (bus.in_data),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk   (clk),
    .we    (acc),
    .addr  (c),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    win_shift = win;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_shift[win_idx(i, j)] = win[win_idx(i, j + 1)];
      end
    end
    win_shift[win_idx(0, K - 1)] = lb1_rd;
    win_shift[win_idx(1, K - 1)] = lb0_rd;
    win_shift[win_idx(2, K - 1)] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      c   <= '0;
      win <= '0;
    end else if (acc) begin
      win <= win_shift;
      if (last_col) begin
        c <= '0;
        r <= last_row ? '0 : r + RW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_win   <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.out_last  <= 1'b0;
    end else if (emit) begin
      bus.out_valid <= 1'b1;
      bus.out_win   <= win_shift;
      bus.out_row   <= r - RW'(2);
      bus.out_col   <= c - CW'(2);
      bus.out_last  <= last_row && last_col;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// tb/tb_conv_window_streamer.sv - randomized self-checking bench against a window model
module tb_conv_window_streamer;
  import cnn_pkg::*;

  typedef struct {
    logic [9*DATA_W-1:0] w;
    int                  row;
    int                  col;
    logic                last;
    int                  k;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_streamer_if #(.IMG_W(4),  .IMG_H(4))  b4  ();
  conv_window_streamer_if #(.IMG_W(28), .IMG_H(28)) b28 ();

  conv_window_streamer #(.IMG_W(4),  .IMG_H(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  conv_window_streamer #(.IMG_W(28), .IMG_H(28)) u28 (.clk(clk), .rst_n(rst_n), .bus(b28));

  int                checks = 0;
  int                passes = 0;
  int                k;
  win_t              got[$];
  logic [DATA_W-1:0] pix [0:1023];

  // Reference: window n of a stream of back-to-back h x w frames, taken straight from
  // the image array in raster order.
  function automatic win_t exp_win(input int h, input int w, input int n);
    win_t e;
    int   nw, f, rem;
    nw     = (h - 2) * (w - 2);
    f      = n / nw;
    rem    = n % nw;
    e.row  = rem / (w - 2);
    e.col  = rem % (w - 2);
    e.last = (e.row == h - 3) && (e.col == w - 3);
    e.k    = 0;
    e.w    = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e.w[DATA_W*(3*i+j) +: DATA_W] = pix[f*h*w + (e.row + i)*w + e.col + j];
    return e;
  endfunction

  task automatic idle_inputs();
    b4.in_valid = 1'b0;  b4.in_data = '0;  b4.out_ready = 1'b0;
    b28.in_valid = 1'b0; b28.in_data = '0; b28.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    got.delete();
  endtask

  // Drives pixels pix[k..npix-1] into one DUT with random duty and records every
  // window handshake; returns the cycle count at which the last pixel was taken.
  task automatic run_stream(input int sel, input int npix, input int vpct, input int rpct,
                            output int acc_cyc);
    int   cyc;
    logic iv, orr, ov;
    win_t t;
    cyc = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      ov = (sel == 0) ? b4.out_valid : b28.out_valid;
      if (k >= npix && !ov) break;
      if (cyc >= 20000) begin
        checks++;
        $display("FAIL stream_timeout: accepted %0d of %0d pixels", k, npix);
        break;
      end
      iv  = (k < npix) && ($urandom_range(0, 99) < vpct);
      orr = ($urandom_range(0, 99) < rpct);
      if (sel == 0) begin
        b4.in_valid = iv; b4.in_data = iv ? pix[k] : '0; b4.out_ready = orr;
      end else begin
        b28.in_valid = iv; b28.in_data = iv ? pix[k] : '0; b28.out_ready = orr;
      end
      #1;
      t.k = k;
      if (sel == 0) begin
        if (b4.out_valid && b4.out_ready) begin
          t.w = b4.out_win; t.row = int'(b4.out_row); t.col = int'(b4.out_col);
          t.last = b4.out_last; got.push_back(t);
        end
        if (b4.in_valid && b4.in_ready) k++;
      end else begin
        if (b28.out_valid && b28.out_ready) begin
          t.w = b28.out_win; t.row = int'(b28.out_row); t.col = int'(b28.out_col);
          t.last = b28.out_last; got.push_back(t);
        end
        if (b28.in_valid && b28.in_ready) k++;
      end
      cyc++;
      if (k == npix && acc_cyc < 0) acc_cyc = cyc;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (b4.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); else passes++;
    checks++; if (b4.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", b4.in_ready); else passes++;
    checks++; if (b4.out_win !== '0) $display("FAIL reset_out_win: got %h want 0", b4.out_win); else passes++;
    checks++; if (b4.out_row !== 2'd0 || b4.out_col !== 2'd0 || b4.out_last !== 1'b0)
      $display("FAIL reset_pos: got row %0d col %0d last %b want 0 0 0", b4.out_row, b4.out_col, b4.out_last); else passes++;
    checks++; if (b28.out_valid !== 1'b0 || b28.in_ready !== 1'b1)
      $display("FAIL reset_28: got out_valid %b in_ready %b want 0 1", b28.out_valid, b28.in_ready); else passes++;
  endtask

  task automatic test_basic();
    int   ac;
    win_t e;
    do_reset();
    for (int i = 0; i < 16; i++) pix[i] = 32'(i);
    run_stream(0, 16, 100, 100, ac);
    checks++; if (got.size() != 4) $display("FAIL basic_count: got %0d want 4", got.size()); else passes++;
    checks++; if (got.size() == 0 || got[0].k != 11)
      $display("FAIL basic_latency: first window seen after %0d pixels want 11", got.size() ? got[0].k : -1); else passes++;
    checks++; if (ac != 16) $display("FAIL basic_throughput: got %0d cycles want 16", ac); else passes++;
    for (int n = 0; n < got.size() && n < 4; n++) begin
      e = exp_win(4, 4, n);
      checks++;
      if (got[n].w !== e.w || got[n].row != e.row || got[n].col != e.col || got[n].last !== e.last)
        $display("FAIL basic_win%0d: got r%0d c%0d last %b %h want r%0d c%0d last %b %h",
                 n, got[n].row, got[n].col, got[n].last, got[n].w, e.row, e.col, e.last, e.w);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int   ac;
    win_t e;
    logic seen;
    do_reset();
    for (int i = 0; i < 16; i++) pix[i] = 32'(i);
    seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b4.out_valid) begin seen = 1'b1; break; end
      b4.in_valid = (k < 16); b4.in_data = pix[k]; b4.out_ready = 1'b0;
      #1;
      if (b4.in_valid && b4.in_ready) k++;
    end
    checks++; if (!seen) $display("FAIL bp_first_window: none after 40 cycles"); else passes++;
    checks++; if (k != 11) $display("FAIL bp_accepted: got %0d pixels want 11", k); else passes++;
    e = exp_win(4, 4, 0);
    for (int h = 0; h < 5; h++) begin
      checks++;
      if (b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1 || b4.out_win !== e.w || b4.out_row !== 2'd0 || b4.out_col !== 2'd0)
        $display("FAIL bp_hold%0d: got in_ready %b out_valid %b win %h want 0 1 %h", h, b4.in_ready, b4.out_valid, b4.out_win, e.w);
      else passes++;
      @(negedge clk);
    end
    run_stream(0, 16, 100, 100, ac);
    checks++; if (got.size() != 4) $display("FAIL bp_count: got %0d want 4", got.size()); else passes++;
    for (int n = 0; n < got.size() && n < 4; n++) begin
      e = exp_win(4, 4, n);
      checks++;
      if (got[n].w !== e.w || got[n].row != e.row || got[n].col != e.col || got[n].last !== e.last)
        $display("FAIL bp_win%0d: got r%0d c%0d %h want r%0d c%0d %h", n, got[n].row, got[n].col, got[n].w, e.row, e.col, e.w);
      else passes++;
    end
  endtask

  task automatic test_random28();
    int   ac, nlast, nbad;
    win_t e;
    do_reset();
    for (int i = 0; i < 784; i++) pix[i] = $urandom;
    run_stream(1, 784, 70, 60, ac);
    checks++; if (got.size() != 676) $display("FAIL rand28_count: got %0d want 676", got.size()); else passes++;
    nlast = 0;
    nbad = 0;
    for (int n = 0; n < got.size() && n < 676; n++) begin
      e = exp_win(28, 28, n);
      if (got[n].last) nlast++;
      checks++;
      if (got[n].w !== e.w || got[n].row != e.row || got[n].col != e.col || got[n].last !== e.last) begin
        nbad++;
        if (nbad <= 5)
          $display("FAIL rand28_win%0d: got r%0d c%0d last %b want r%0d c%0d last %b",
                   n, got[n].row, got[n].col, got[n].last, e.row, e.col, e.last);
      end else passes++;
    end
    checks++; if (nlast != 1) $display("FAIL rand28_last_count: got %0d want 1", nlast); else passes++;
  endtask

  task automatic test_opaque();
    int ac;
    do_reset();
    pix[0] = 32'hBF9FD2A6;
    for (int i = 1; i < 16; i++) pix[i] = $urandom;
    run_stream(0, 16, 80, 70, ac);
    checks++;
    if (got.size() == 0) $display("FAIL opaque: got no window want one");
    else if (got[0].w[DATA_W-1:0] !== 32'hBF9FD2A6 || got[0].row != 0 || got[0].col != 0)
      $display("FAIL opaque: got %h at r%0d c%0d want bf9fd2a6 at r0 c0", got[0].w[DATA_W-1:0], got[0].row, got[0].col);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int   ac;
    win_t e;
    do_reset();
    for (int i = 0; i < 16; i++) pix[i] = 32'(i);
    run_stream(0, 7, 100, 100, ac);
    @(negedge clk);
    b4.in_valid = 1'b1; b4.in_data = pix[7]; b4.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1)
      $display("FAIL midreset_clear: got out_valid %b in_ready %b want 0 1", b4.out_valid, b4.in_ready); else passes++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    k = 0;
    got.delete();
    for (int i = 0; i < 16; i++) pix[i] = 32'(100 + i);
    run_stream(0, 16, 100, 100, ac);
    checks++; if (got.size() != 4) $display("FAIL midreset_count: got %0d want 4", got.size()); else passes++;
    for (int n = 0; n < got.size() && n < 4; n++) begin
      e = exp_win(4, 4, n);
      checks++;
      if (got[n].w !== e.w || got[n].row != e.row || got[n].col != e.col)
        $display("FAIL midreset_win%0d: got r%0d c%0d %h want r%0d c%0d %h", n, got[n].row, got[n].col, got[n].w, e.row, e.col, e.w);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int   ac;
    win_t e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pix[i]      = 32'(i);
      pix[16 + i] = 32'(200 + i);
    end
    run_stream(0, 32, 100, 100, ac);
    checks++; if (got.size() != 8) $display("FAIL b2b_count: got %0d want 8", got.size()); else passes++;
    checks++; if (ac != 32) $display("FAIL b2b_no_bubble: got %0d cycles want 32", ac); else passes++;
    for (int n = 0; n < got.size() && n < 8; n++) begin
      e = exp_win(4, 4, n);
      checks++;
      if (got[n].w !== e.w || got[n].row != e.row || got[n].col != e.col || got[n].last !== e.last)
        $display("FAIL b2b_win%0d: got r%0d c%0d last %b %h want r%0d c%0d last %b %h",
                 n, got[n].row, got[n].col, got[n].last, got[n].w, e.row, e.col, e.last, e.w);
      else passes++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_random28();
    test_opaque();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
